sal_cmd_sched: RTL and testbench
================================

Name: sal_cmd_sched

Overview:
- Per-channel command scheduler directly downstream of the per-bank controllers.
- Each cycle it takes ACT/RD/WR/PRE/REF requests from NUM_BANKS bank controllers and grants at most one, in the same cycle.
- It enforces the inter-bank timing constraints tRRD, tCCD, tWTR and tRTW.
- It registers the winning command toward the DFI/PHY command encoder.

Parameters:
NUM_BANKS, 4, number of bank controllers served (power of 2)
BA_WIDTH, 2, bank address width, equals log2(NUM_BANKS)
RA_WIDTH, 16, row address width
CA_WIDTH, 10, column address width
ID_WIDTH, 4, transaction ID width
LEN_WIDTH, 4, burst length field width
CNTR_WIDTH, 4, width of every timing value and counter

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
act_req_i  in  NUM_BANKS  per-bank ACTIVATE request
rd_req_i  in  NUM_BANKS  per-bank READ request
wr_req_i  in  NUM_BANKS  per-bank WRITE request
pre_req_i  in  NUM_BANKS  per-bank PRECHARGE request
ref_req_i  in  NUM_BANKS  per-bank REFRESH request
ra_i  in  NUM_BANKS*RA_WIDTH  per-bank row address, bank b at [b*RA_WIDTH +: RA_WIDTH]
ca_i  in  NUM_BANKS*CA_WIDTH  per-bank column address
id_i  in  NUM_BANKS*ID_WIDTH  per-bank transaction ID
len_i  in  NUM_BANKS*LEN_WIDTH  per-bank burst length
act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  out  NUM_BANKS each  per-bank grants, combinational
t_rrd_m1_i, t_ccd_m1_i, t_wtr_m1_i, t_rtw_m1_i  in  CNTR_WIDTH each  quasi-static timing values minus 1
cmd_valid_o  out  1  registered command valid
cmd_type_o  out  3  0=ACT 1=RD 2=WR 3=PRE 4=REF
cmd_ba_o  out  BA_WIDTH  bank of command
cmd_ra_o  out  RA_WIDTH  row address, valid for ACT
cmd_ca_o  out  CA_WIDTH  column address, valid for RD/WR
cmd_id_o  out  ID_WIDTH  transaction ID, valid for RD/WR
cmd_len_o  out  LEN_WIDTH  burst length, valid for RD/WR

Behaviour:
- Grant rules:
  - At most one grant bit asserted across all grant vectors per cycle.
  - A grant is asserted only with its matching request in the same cycle; it is purely combinational from requests, counters and the RR pointer.
  - Requests may drop without a grant; no state is held for ungranted requests.
- Class priority, highest first: REF > RD/WR (column) > ACT > PRE.
  - A class is eligible only if at least one bank requests it and its timing is met.
  - RD and WR are one class; the bank order decides between them.
  - A bank asserting several request types: only its highest-priority eligible type competes.
- Bank order within a class: round-robin.
  - The search starts at rr_ptr and wraps modulo NUM_BANKS.
  - After any grant, rr_ptr <= granted bank + 1 (wraps). With no grant, rr_ptr holds.
- Timing counters (CNTR_WIDTH each): rrd, ccd, wtr, rtw.
  - A counter loads its m1 value on the enabling grant and otherwise decrements to 0, saturating there.
  - A constraint is met when its counter == 0, so a value m1=k enforces a minimum spacing of k+1 cycles; k=0 allows back-to-back commands.
  - rrd: loaded on ACT grant; gates ACT.
  - ccd: loaded on RD or WR grant; gates RD and WR.
  - wtr: loaded on WR grant; gates RD.
  - rtw: loaded on RD grant; gates WR.
  - PRE and REF are not gated here; per-bank timing is the bank controller's job.
  - If a load and a decrement fall in the same cycle, the load wins.
- Output register:
  - A grant at cycle t appears on the cmd_* outputs at cycle t+1 with cmd_valid_o=1.
  - With no grant, cmd_valid_o=0 and the other cmd_* fields hold their previous values.
  - cmd_ra_o, cmd_ca_o, cmd_id_o and cmd_len_o are captured from the granted bank's slices regardless of command type.
- Reset (asynchronous, rst_n low):
  - cmd_valid_o=0, cmd_type_o=0, cmd_ba/ra/ca/id/len_o=0.
  - All counters 0 (met), rr_ptr=0.
  - Grants are 0 while reset is held, since requests are masked.
  - Reset mid-operation drops any pending output command; no replay.
- Timing inputs must not change while any counter is nonzero; behaviour otherwise is undefined.

Optional Feature:
- Macro: SAL_TFAW_EN.
- When defined:
  - Adds port t_faw_m1_i (in, CNTR_WIDTH+2).
  - Adds 4 window counters. Each ACT grant loads the oldest zero slot with t_faw_m1_i.
  - ACT is eligible only if rrd==0 and at least one slot == 0, i.e. at most 4 ACTs in any t_faw_m1_i+1 cycle window.
- When undefined: the port is absent and ACT is gated by rrd only.

Test Plan:
- Reset release, bank 2 asserts act_req_i with ra=0x1234 -> act_gnt_o[2]=1 the same cycle; next cycle cmd_valid_o=1, cmd_type_o=0, cmd_ba_o=2, cmd_ra_o=0x1234.
- Banks 0 and 1 both request ACT continuously with t_rrd_m1_i=3 -> ACT grants exactly every 4 cycles, alternating bank 0, 1, 0, 1.
- Same cycle: bank 0 REF, bank 1 RD, bank 2 ACT, bank 3 PRE -> grants in consecutive cycles in order REF(0), RD(1), ACT(2), PRE(3), with timing values at 0.
- WR granted at cycle t with t_wtr_m1_i=5, t_ccd_m1_i=1, RD pending on another bank -> rd_gnt_o first asserts at t+6; a second WR is allowed at t+2.
- Assert rst_n low while cmd_valid_o=1 and rrd=3 -> outputs go to 0 immediately; after release, an ACT is granted on the first request cycle.
- SAL_TFAW_EN with t_faw_m1_i=19, t_rrd_m1_i=0, 4 banks requesting ACT -> 4 ACTs at t..t+3, the 5th no earlier than t+20.

Source files
------------

// File: rtl/sal_cmd_if.sv
// Bank-controller request/grant bus plus registered command toward the PHY.
// Signal names keep their _i/_o suffixes relative to the scheduler.
interface sal_cmd_if #(
  parameter int NUM_BANKS = 4,
  parameter int BA_WIDTH  = 2,
  parameter int RA_WIDTH  = 16,
  parameter int CA_WIDTH  = 10,
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 4
);
  logic [NUM_BANKS-1:0]           act_req_i;
  logic [NUM_BANKS-1:0]           rd_req_i;
  logic [NUM_BANKS-1:0]           wr_req_i;
  logic [NUM_BANKS-1:0]           pre_req_i;
  logic [NUM_BANKS-1:0]           ref_req_i;
  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i;
  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i;
  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i;
  logic [NUM_BANKS*LEN_WIDTH-1:0] len_i;
  logic [NUM_BANKS-1:0]           act_gnt_o;
  logic [NUM_BANKS-1:0]           rd_gnt_o;
  logic [NUM_BANKS-1:0]           wr_gnt_o;
  logic [NUM_BANKS-1:0]           pre_gnt_o;
  logic [NUM_BANKS-1:0]           ref_gnt_o;
  logic                           cmd_valid_o;
  logic [2:0]                     cmd_type_o;
  logic [BA_WIDTH-1:0]            cmd_ba_o;
  logic [RA_WIDTH-1:0]            cmd_ra_o;
  logic [CA_WIDTH-1:0]            cmd_ca_o;
  logic [ID_WIDTH-1:0]            cmd_id_o;
  logic [LEN_WIDTH-1:0]           cmd_len_o;

  modport master (
    output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i,
    output ra_i, ca_i, id_i, len_i,
    input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
    input  cmd_valid_o, cmd_type_o, cmd_ba_o, cmd_ra_o,
    input  cmd_ca_o, cmd_id_o, cmd_len_o
  );

  modport slave (
    input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i,
    input  ra_i, ca_i, id_i, len_i,
    output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
    output cmd_valid_o, cmd_type_o, cmd_ba_o, cmd_ra_o,
    output cmd_ca_o, cmd_id_o, cmd_len_o
  );
endinterface

// File: rtl/sal_cmd_sched.sv
// Per-channel DRAM command scheduler: class priority, RR banks, tRRD/tCCD/tWTR/tRTW.
// Optional SAL_TFAW_EN adds a four-activate window limiter.
module sal_cmd_sched #(
  parameter int NUM_BANKS  = 4,
  parameter int BA_WIDTH   = 2,
  parameter int RA_WIDTH   = 16,
  parameter int CA_WIDTH   = 10,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int CNTR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sal_cmd_if.slave              bus,
  input  logic [CNTR_WIDTH-1:0] t_rrd_m1_i,
  input  logic [CNTR_WIDTH-1:0] t_ccd_m1_i,
  input  logic [CNTR_WIDTH-1:0] t_wtr_m1_i,
  input  logic [CNTR_WIDTH-1:0] t_rtw_m1_i
`ifdef SAL_TFAW_EN
  ,
  input  logic [CNTR_WIDTH+1:0] t_faw_m1_i
`endif
);
  localparam int N  = NUM_BANKS;
  localparam int CW = CNTR_WIDTH;

  typedef enum logic [2:0] {
    ACT = 3'd0,
    RD  = 3'd1,
    WR  = 3'd2,
    PRE = 3'd3,
    REF = 3'd4
  } cmd_e;

  logic [CW-1:0]       rrd, ccd, wtr, rtw;
  logic [BA_WIDTH-1:0] rr_ptr, gnt_ba, idx;
  logic                act_ok, rd_ok, wr_ok, found;
  logic [N-1:0]        en, e_ref, e_rd, e_wr, e_act, e_pre;
  logic [N-1:0]        cand, onehot;
  cmd_e                gnt_type;

  assign rd_ok = (ccd == '0) && (wtr == '0);
  assign wr_ok = (ccd == '0) && (rtw == '0);

`ifdef SAL_TFAW_EN
  localparam int FW = CW + 2;
  logic [FW-1:0] faw [4];
  logic [1:0]    faw_sel;
  logic          faw_free;

  always_comb begin
    faw_sel  = '0;
    faw_free = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (faw[i] == '0) begin
        faw_sel  = 2'(i);
        faw_free = 1'b1;
      end
    end
  end

  assign act_ok = (rrd == '0) && faw_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) faw[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (|bus.act_gnt_o && faw_sel == 2'(i))
          faw[i] <= t_faw_m1_i;
        else if (faw[i] != '0)
          faw[i] <= faw[i] - FW'(1);
      end
    end
  end
`else
  assign act_ok = (rrd == '0);
`endif

  // Each bank offers only its highest-priority eligible request.
  assign en    = {N{rst_n}};
  assign e_ref = en & bus.ref_req_i;
  assign e_rd  = en & ~e_ref & bus.rd_req_i & {N{rd_ok}};
  assign e_wr  = en & ~e_ref & ~e_rd & bus.wr_req_i & {N{wr_ok}};
  assign e_act = en & ~e_ref & ~e_rd & ~e_wr
               & bus.act_req_i & {N{act_ok}};
  assign e_pre = en & ~e_ref & ~e_rd & ~e_wr & ~e_act
               & bus.pre_req_i;

  always_comb begin
    cand = e_pre;
    priority case (1'b1)
      |e_ref:         cand = e_ref;
      |(e_rd | e_wr): cand = e_rd | e_wr;
      |e_act:         cand = e_act;
      default:        cand = e_pre;
    endcase
  end

  always_comb begin
    found  = 1'b0;
    gnt_ba = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = rr_ptr + BA_WIDTH'(i);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        gnt_ba = idx;
      end
    end
  end

  assign onehot        = {{(N-1){1'b0}}, found} << gnt_ba;
  assign bus.act_gnt_o = onehot & e_act;
  assign bus.rd_gnt_o  = onehot & e_rd;
  assign bus.wr_gnt_o  = onehot & e_wr;
  assign bus.pre_gnt_o = onehot & e_pre;
  assign bus.ref_gnt_o = onehot & e_ref;

  always_comb begin
    gnt_type = ACT;
    unique case (1'b1)
      |bus.rd_gnt_o:  gnt_type = RD;
      |bus.wr_gnt_o:  gnt_type = WR;
      |bus.pre_gnt_o: gnt_type = PRE;
      |bus.ref_gnt_o: gnt_type = REF;
      default:        gnt_type = ACT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd    <= '0;
      ccd    <= '0;
      wtr    <= '0;
      rtw    <= '0;
      rr_ptr <= '0;
    end else begin
      if (|bus.act_gnt_o)       rrd <= t_rrd_m1_i;
      else if (rrd != '0)       rrd <= rrd - CW'(1);
      if (|(bus.rd_gnt_o | bus.wr_gnt_o))
                                ccd <= t_ccd_m1_i;
      else if (ccd != '0)       ccd <= ccd - CW'(1);
      if (|bus.wr_gnt_o)        wtr <= t_wtr_m1_i;
      else if (wtr != '0)       wtr <= wtr - CW'(1);
      if (|bus.rd_gnt_o)        rtw <= t_rtw_m1_i;
      else if (rtw != '0)       rtw <= rtw - CW'(1);
      if (found)                rr_ptr <= gnt_ba + BA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_valid_o <= 1'b0;
      bus.cmd_type_o  <= '0;
      bus.cmd_ba_o    <= '0;
      bus.cmd_ra_o    <= '0;
      bus.cmd_ca_o    <= '0;
      bus.cmd_id_o    <= '0;
      bus.cmd_len_o   <= '0;
    end else begin
      bus.cmd_valid_o <= found;
      if (found) begin
        bus.cmd_type_o <= gnt_type;
        bus.cmd_ba_o   <= gnt_ba;
        bus.cmd_ra_o   <= bus.ra_i[gnt_ba*RA_WIDTH +: RA_WIDTH];
        bus.cmd_ca_o   <= bus.ca_i[gnt_ba*CA_WIDTH +: CA_WIDTH];
        bus.cmd_id_o   <= bus.id_i[gnt_ba*ID_WIDTH +: ID_WIDTH];
        bus.cmd_len_o  <= bus.len_i[gnt_ba*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed scenarios plus random traffic
// against a cycle-time based reference model.
module tb_sal_cmd_sched;
  localparam int N   = 4;
  localparam int BA  = 2;
  localparam int RA  = 16;
  localparam int CA  = 10;
  localparam int ID  = 4;
  localparam int LEN = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] t_rrd, t_ccd, t_wtr, t_rtw;
  logic [CW+1:0] t_faw;

  sal_cmd_if #(.NUM_BANKS(N), .BA_WIDTH(BA), .RA_WIDTH(RA),
    .CA_WIDTH(CA), .ID_WIDTH(ID), .LEN_WIDTH(LEN)) bus ();

  sal_cmd_sched #(.NUM_BANKS(N), .BA_WIDTH(BA), .RA_WIDTH(RA),
    .CA_WIDTH(CA), .ID_WIDTH(ID), .LEN_WIDTH(LEN),
    .CNTR_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .t_rrd_m1_i (t_rrd),
    .t_ccd_m1_i (t_ccd),
    .t_wtr_m1_i (t_wtr),
    .t_rtw_m1_i (t_rtw)
`ifdef SAL_TFAW_EN
    ,
    .t_faw_m1_i (t_faw)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model: timestamps of past grants, not counters
  int cyc = 0;
  int last_act, last_col, last_rd, last_wr, rr;
  int act_q[$];
  logic           e_valid;
  logic [2:0]     e_type;
  logic [BA-1:0]  e_ba;
  logic [RA-1:0]  e_ra;
  logic [CA-1:0]  e_ca;
  logic [ID-1:0]  e_id;
  logic [LEN-1:0] e_len;
  int g_typ, g_bank;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rank_of(input int t);
    case (t)
      4:       return 3;
      1, 2:    return 2;
      0:       return 1;
      3:       return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int window_acts();
    int n = 0;
    foreach (act_q[i]) if (cyc - act_q[i] <= int'(t_faw)) n++;
    return n;
  endfunction

  task automatic model_pick(output int typ, output int bank);
    int best [N];
    int top, b;
    bit aok, rok, wok;
    aok = (cyc - last_act) > int'(t_rrd);
`ifdef SAL_TFAW_EN
    aok = aok && (window_acts() < 4);
`endif
    rok = (cyc - last_col > int'(t_ccd)) && (cyc - last_wr > int'(t_wtr));
    wok = (cyc - last_col > int'(t_ccd)) && (cyc - last_rd > int'(t_rtw));
    top = -1;
    for (int i = 0; i < N; i++) begin
      if (bus.ref_req_i[i])               best[i] = 4;
      else if (bus.rd_req_i[i] && rok)    best[i] = 1;
      else if (bus.wr_req_i[i] && wok)    best[i] = 2;
      else if (bus.act_req_i[i] && aok)   best[i] = 0;
      else if (bus.pre_req_i[i])          best[i] = 3;
      else                                best[i] = -1;
      if (rank_of(best[i]) > top) top = rank_of(best[i]);
    end
    typ = -1;
    bank = 0;
    for (int o = 0; o < N; o++) begin
      b = (rr + o) % N;
      if (typ < 0 && best[b] >= 0 && rank_of(best[b]) == top) begin
        typ = best[b];
        bank = b;
      end
    end
  endtask

  task automatic step();
    int typ, bank;
    logic [N-1:0] eg [5];
    #1;
    model_pick(typ, bank);
    for (int k = 0; k < 5; k++) eg[k] = '0;
    if (typ >= 0) eg[typ][bank] = 1'b1;
    check("act_gnt", 64'(bus.act_gnt_o), 64'(eg[0]));
    check("rd_gnt",  64'(bus.rd_gnt_o),  64'(eg[1]));
    check("wr_gnt",  64'(bus.wr_gnt_o),  64'(eg[2]));
    check("pre_gnt", 64'(bus.pre_gnt_o), 64'(eg[3]));
    check("ref_gnt", 64'(bus.ref_gnt_o), 64'(eg[4]));
    check("cmd_valid", 64'(bus.cmd_valid_o), 64'(e_valid));
    check("cmd_type",  64'(bus.cmd_type_o),  64'(e_type));
    check("cmd_ba",    64'(bus.cmd_ba_o),    64'(e_ba));
    check("cmd_ra",    64'(bus.cmd_ra_o),    64'(e_ra));
    check("cmd_ca",    64'(bus.cmd_ca_o),    64'(e_ca));
    check("cmd_id",    64'(bus.cmd_id_o),    64'(e_id));
    check("cmd_len",   64'(bus.cmd_len_o),   64'(e_len));
    @(posedge clk);
    e_valid = (typ >= 0);
    if (typ >= 0) begin
      e_type = 3'(typ);
      e_ba   = BA'(bank);
      e_ra   = bus.ra_i[bank*RA +: RA];
      e_ca   = bus.ca_i[bank*CA +: CA];
      e_id   = bus.id_i[bank*ID +: ID];
      e_len  = bus.len_i[bank*LEN +: LEN];
      if (typ == 0) begin
        last_act = cyc;
        act_q.push_back(cyc);
      end
      if (typ == 1) last_rd = cyc;
      if (typ == 2) last_wr = cyc;
      if (typ == 1 || typ == 2) last_col = cyc;
      rr = (bank + 1) % N;
    end
    g_typ = typ;
    g_bank = bank;
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.act_req_i = '0;
    bus.rd_req_i  = '0;
    bus.wr_req_i  = '0;
    bus.pre_req_i = '0;
    bus.ref_req_i = '0;
  endtask

  task automatic do_reset(input int rrd, ccd, wtr, rtw, faw);
    rst_n = 1'b0;
    t_rrd = CW'(rrd);
    t_ccd = CW'(ccd);
    t_wtr = CW'(wtr);
    t_rtw = CW'(rtw);
    t_faw = (CW+2)'(faw);
    #1;
    check("rst_valid", 64'(bus.cmd_valid_o), 64'(0));
    check("rst_fields", 64'(|{bus.cmd_type_o, bus.cmd_ba_o, bus.cmd_ra_o,
          bus.cmd_ca_o, bus.cmd_id_o, bus.cmd_len_o}), 64'(0));
    check("rst_gnts", 64'(|{bus.act_gnt_o, bus.rd_gnt_o, bus.wr_gnt_o,
          bus.pre_gnt_o, bus.ref_gnt_o}), 64'(0));
    e_valid = 0; e_type = 0; e_ba = 0; e_ra = 0;
    e_ca = 0; e_id = 0; e_len = 0;
    last_act = cyc - 1000;
    last_col = cyc - 1000;
    last_rd  = cyc - 1000;
    last_wr  = cyc - 1000;
    rr = 0;
    act_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_payload();
    for (int b = 0; b < N; b++) begin
      bus.ra_i[b*RA +: RA]    = RA'($urandom);
      bus.ca_i[b*CA +: CA]    = CA'($urandom);
      bus.id_i[b*ID +: ID]    = ID'($urandom);
      bus.len_i[b*LEN +: LEN] = LEN'($urandom);
    end
  endtask

  initial begin
    clear_reqs();
    bus.ra_i = '0; bus.ca_i = '0; bus.id_i = '0; bus.len_i = '0;
    @(negedge clk);

    // single ACT on bank 2
    do_reset(0, 0, 0, 0, 0);
    bus.ra_i[2*RA +: RA] = 16'h1234;
    bus.act_req_i[2] = 1'b1;
    step();
    check("t1_gnt_type", 64'(g_typ), 64'(0));
    check("t1_gnt_bank", 64'(g_bank), 64'(2));
    clear_reqs();
    check("t1_valid", 64'(bus.cmd_valid_o), 64'(1));
    check("t1_type", 64'(bus.cmd_type_o), 64'(0));
    check("t1_ba", 64'(bus.cmd_ba_o), 64'(2));
    check("t1_ra", 64'(bus.cmd_ra_o), 64'h1234);
    step();

    // tRRD spacing, RR alternation
    do_reset(3, 0, 0, 0, 0);
    bus.act_req_i = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t2_typ", 64'(g_typ), (i % 4 == 0) ? 64'(0) : 64'hFFFF_FFFF_FFFF_FFFF);
      if (i % 4 == 0) check("t2_bank", 64'(g_bank), 64'((i / 4) % 2));
    end
    clear_reqs();

    // class priority order
    do_reset(0, 0, 0, 0, 0);
    bus.ref_req_i[0] = 1'b1;
    bus.rd_req_i[1]  = 1'b1;
    bus.act_req_i[2] = 1'b1;
    bus.pre_req_i[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_typ", 64'(g_typ), 64'((i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 0 : 3));
      check("t3_bank", 64'(g_bank), 64'(i));
      if (g_typ >= 0) begin
        bus.ref_req_i[g_bank] = 1'b0;
        bus.rd_req_i[g_bank]  = 1'b0;
        bus.act_req_i[g_bank] = 1'b0;
        bus.pre_req_i[g_bank] = 1'b0;
      end
    end

    // tWTR blocks RD for six cycles
    do_reset(0, 1, 5, 0, 0);
    bus.wr_req_i[0] = 1'b1;
    bus.rd_req_i[1] = 1'b1;
    step();
    check("t4_wr", 64'(g_typ), 64'(2));
    bus.wr_req_i[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("t4_rd_wait", 64'(g_typ), (i == 6) ? 64'(1) : 64'hFFFF_FFFF_FFFF_FFFF);
    end
    clear_reqs();

    // tCCD allows WR again two cycles later
    do_reset(0, 1, 5, 0, 0);
    bus.wr_req_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_wr2", 64'(g_typ), (i == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(2));
    end
    clear_reqs();

    // reset while a command is being issued
    do_reset(3, 0, 0, 0, 0);
    bus.act_req_i[0] = 1'b1;
    step();
    check("t5_valid", 64'(bus.cmd_valid_o), 64'(1));
    do_reset(3, 0, 0, 0, 0);
    step();
    check("t5_act_after", 64'(g_typ), 64'(0));
    clear_reqs();

`ifdef SAL_TFAW_EN
    // four-activate window
    do_reset(0, 0, 0, 0, 19);
    bus.act_req_i = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      step();
      check("faw_typ", 64'(g_typ),
            (i < 4 || i >= 20) ? 64'(0) : 64'hFFFF_FFFF_FFFF_FFFF);
    end
    clear_reqs();
`endif

    // random traffic, timing fixed per segment
    for (int s = 0; s < 4; s++) begin
      do_reset($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(4, 15));
      for (int i = 0; i < 200; i++) begin
        for (int b = 0; b < N; b++) begin
          bus.act_req_i[b] = ($urandom_range(0, 9) < 4);
          bus.rd_req_i[b]  = ($urandom_range(0, 9) < 3);
          bus.wr_req_i[b]  = ($urandom_range(0, 9) < 3);
          bus.pre_req_i[b] = ($urandom_range(0, 9) < 2);
          bus.ref_req_i[b] = ($urandom_range(0, 19) < 1);
        end
        rand_payload();
        step();
      end
    end
    clear_reqs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
